// File: rtl/pulse_analyzer_pkg.sv
// Shared types and sizes for the pulse analyzer.
// Record layout is what readout sees on the result port.
package pulse_analyzer_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int SIZE_TIME        = 32;
    localparam int SIZE_WIDTH       = 12;
    localparam int SIZE_LOST        = 16;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude;
        logic [SIZE_TIME-1:0]               peak_time;
        logic [SIZE_WIDTH-1:0]              pulse_width;
        logic                               pileup;
        logic                               width_ovf;
    } pulse_record_t;

    typedef enum logic {PA_IDLE, PA_ABOVE} pa_state_t;

endpackage

// File: rtl/pulse_result_reg.sv
// Single-entry valid/ready holding register for pulse records.
// A record arriving while one is stuck downstream is dropped and counted.
module pulse_result_reg
    import pulse_analyzer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 emit,
    input  pulse_record_t        rec_in,
    input  logic                 result_ready,
    output logic                 result_valid,
    output pulse_record_t        rec_out,
    output logic [SIZE_LOST-1:0] lost_count
);

    logic load;

    assign load = emit && (!result_valid || result_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid <= 1'b0;
            rec_out      <= '0;
            lost_count   <= '0;
        end else if (load) begin
            result_valid <= 1'b1;
            rec_out      <= rec_in;
        end else if (emit) begin
            if (!(&lost_count))
                lost_count <= lost_count + 1'b1;
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_analyzer.sv
// Threshold/hysteresis pulse detector with peak, timestamp, width
// and pile-up capture; records leave through pulse_result_reg.
module pulse_analyzer
    import pulse_analyzer_pkg::*;
#(
    parameter int THRESHOLD  = 100,
    parameter int HYSTERESIS = 20,
    parameter int SIZE_TIME  = pulse_analyzer_pkg::SIZE_TIME,
    parameter int SIZE_WIDTH = pulse_analyzer_pkg::SIZE_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    input  logic                               result_ready,
    output logic                               result_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
    output logic [SIZE_TIME-1:0]               peak_time,
    output logic [SIZE_WIDTH-1:0]              pulse_width,
    output logic                               pileup,
    output logic                               width_ovf,
    output logic [SIZE_LOST-1:0]               lost_count
);

    // One extra bit so level arithmetic never wraps.
    localparam int W = SIZE_FILTER_DATA + 1;
    localparam logic signed [W-1:0] THR_X = W'(THRESHOLD);
    localparam logic signed [W-1:0] END_X = W'(THRESHOLD - HYSTERESIS);
    localparam logic signed [W-1:0] HYS_X = W'(HYSTERESIS);

    logic signed [SIZE_FILTER_DATA-1:0] data_r;
    logic [SIZE_TIME-1:0]               ts;
    logic                               ts_run;
    pa_state_t                          state;

    logic signed [SIZE_FILTER_DATA-1:0] peak;
    logic signed [SIZE_FILTER_DATA-1:0] lmin;
    logic [SIZE_TIME-1:0]               ptime;
    logic [SIZE_WIDTH-1:0]              width;
    logic                               pile;
    logic                               ovf;

    logic signed [W-1:0] data_x;
    logic signed [W-1:0] lmin_hys;
    logic                above_start;
    logic                above_hold;
    logic                emit;
    pulse_record_t       rec_in;
    pulse_record_t       rec_out;

    assign data_x      = W'(data_r);
    assign lmin_hys    = W'(lmin) + HYS_X;
    assign above_start = data_x > THR_X;
    assign above_hold  = data_x > END_X;
    assign emit        = (state == PA_ABOVE) && !above_hold;

    assign rec_in = '{
        peak_amplitude: peak,
        peak_time:      ptime,
        pulse_width:    width,
        pileup:         pile,
        width_ovf:      ovf
    };

    // ts stays at 0 for the first captured sample after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= '0;
            ts     <= '0;
            ts_run <= 1'b0;
        end else begin
            data_r <= input_data;
            ts_run <= 1'b1;
            if (ts_run)
                ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PA_IDLE;
            peak  <= '0;
            lmin  <= '0;
            ptime <= '0;
            width <= '0;
            pile  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                PA_IDLE: begin
                    if (above_start) begin
                        state <= PA_ABOVE;
                        peak  <= data_r;
                        ptime <= ts;
                        width <= SIZE_WIDTH'(1);
                        lmin  <= data_r;
                        pile  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                PA_ABOVE: begin
                    if (above_hold) begin
                        if (&width)
                            ovf <= 1'b1;
                        else
                            width <= width + 1'b1;
                        if (data_r > peak) begin
                            peak  <= data_r;
                            ptime <= ts;
                            lmin  <= data_r;
                        end else if (data_r < lmin) begin
                            lmin <= data_r;
                        end else if (data_x > lmin_hys) begin
                            pile <= 1'b1;
                        end
                    end else begin
                        state <= PA_IDLE;
                    end
                end
                default: state <= PA_IDLE;
            endcase
        end
    end

    pulse_result_reg u_result (
        .clk          (clk),
        .reset        (reset),
        .emit         (emit),
        .rec_in       (rec_in),
        .result_ready (result_ready),
        .result_valid (result_valid),
        .rec_out      (rec_out),
        .lost_count   (lost_count)
    );

    assign peak_amplitude = rec_out.peak_amplitude;
    assign peak_time      = rec_out.peak_time;
    assign pulse_width    = rec_out.pulse_width;
    assign pileup         = rec_out.pileup;
    assign width_ovf      = rec_out.width_ovf;

endmodule

// File: tb/tb_pulse_analyzer.sv
// Bench for pulse_analyzer: directed table, corner sequences and
// random streams against a pulse-level reference model.
module tb_pulse_analyzer;
    import pulse_analyzer_pkg::*;

    localparam int TH = 100;
    localparam int HY = 20;

    logic                               clk = 1'b0;
    logic                               reset;
    logic signed [SIZE_FILTER_DATA-1:0] input_data;
    logic                               result_ready;
    logic                               result_valid;
    logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude;
    logic [SIZE_TIME-1:0]               peak_time;
    logic [SIZE_WIDTH-1:0]              pulse_width;
    logic                               pileup;
    logic                               width_ovf;
    logic [SIZE_LOST-1:0]               lost_count;

    always #5 clk = ~clk;

    pulse_analyzer #(
        .THRESHOLD  (TH),
        .HYSTERESIS (HY),
        .SIZE_TIME  (SIZE_TIME),
        .SIZE_WIDTH (SIZE_WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .input_data     (input_data),
        .result_ready   (result_ready),
        .result_valid   (result_valid),
        .peak_amplitude (peak_amplitude),
        .peak_time      (peak_time),
        .pulse_width    (pulse_width),
        .pileup         (pileup),
        .width_ovf      (width_ovf),
        .lost_count     (lost_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: whole pulses are buffered, then summarised.
    int     mvals[$];
    longint mt0;
    bit     in_pulse;
    int     d_prev;
    longint ts_prev, ts_next;
    bit     e_valid, e_pile, e_ovf;
    int     e_peak, e_w, e_lost;
    longint e_pt;
    int     r_peak, r_w;
    longint r_pt;
    bit     r_pile, r_ovf;

    int     valid_cnt, first_valid;
    longint cap_peak, cap_pt, cap_w, cap_pile, cap_ovf;

    task automatic summarise();
        int n, idx;
        n = mvals.size();
        r_peak = mvals[0];
        idx = 0;
        foreach (mvals[i]) if (mvals[i] > r_peak) begin
            r_peak = mvals[i];
            idx = i;
        end
        r_pt  = (mt0 + idx) & 64'hFFFF_FFFF;
        r_w   = n > 4095 ? 4095 : n;
        r_ovf = n > 4095;
        r_pile = 0;
        // A later sample that is not a new maximum yet rises more than
        // HY above the lowest point seen since the maximum was reached.
        for (int j = 1; j < n && !r_pile; j++) begin
            int mx, p, mn;
            mx = mvals[0];
            p = 0;
            for (int i = 1; i < j; i++)
                if (mvals[i] > mx) begin mx = mvals[i]; p = i; end
            mn = mvals[p];
            for (int i = p; i < j; i++)
                if (mvals[i] < mn) mn = mvals[i];
            if (mvals[j] <= mx && mvals[j] > mn + HY) r_pile = 1;
        end
    endtask

    task automatic model_sample(int s, longint ts, output bit em);
        em = 0;
        if (!in_pulse) begin
            if (s > TH) begin
                in_pulse = 1;
                mvals = {s};
                mt0 = ts;
            end
        end else if (s > TH - HY) begin
            mvals.push_back(s);
        end else begin
            in_pulse = 0;
            em = 1;
            summarise();
        end
    endtask

    task automatic model_reset();
        in_pulse = 0; mvals = {};
        d_prev = 0; ts_prev = 0; ts_next = 0;
        e_valid = 0; e_peak = 0; e_pt = 0; e_w = 0;
        e_pile = 0; e_ovf = 0; e_lost = 0;
    endtask

    task automatic step(int d, bit rdy);
        bit em;
        @(negedge clk);
        reset = 1'b0;
        input_data = SIZE_FILTER_DATA'(d);
        result_ready = rdy;
        @(posedge clk);
        model_sample(d_prev, ts_prev, em);
        if (em) begin
            if (!e_valid || rdy) begin
                e_valid = 1; e_peak = r_peak; e_pt = r_pt;
                e_w = r_w; e_pile = r_pile; e_ovf = r_ovf;
            end else if (e_lost < 65535) begin
                e_lost++;
            end
        end else if (e_valid && rdy) begin
            e_valid = 0;
        end
        d_prev = d;
        ts_prev = ts_next;
        ts_next++;
        #1;
        check("valid", result_valid, e_valid);
        check("peak", peak_amplitude, e_peak);
        check("peak_time", peak_time, e_pt);
        check("width", pulse_width, e_w);
        check("pileup", pileup, e_pile);
        check("width_ovf", width_ovf, e_ovf);
        check("lost", lost_count, e_lost);
        if (result_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = int'(ts_prev) + 1;
            cap_peak = peak_amplitude; cap_pt = peak_time;
            cap_w = pulse_width; cap_pile = pileup; cap_ovf = width_ovf;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        input_data = '0;
        result_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", result_valid, 0);
        check("rst_peak", peak_amplitude, 0);
        check("rst_time", peak_time, 0);
        check("rst_width", pulse_width, 0);
        check("rst_pile", pileup, 0);
        check("rst_ovf", width_ovf, 0);
        check("rst_lost", lost_count, 0);
        model_reset();
        valid_cnt = 0;
        first_valid = -1;
    endtask

    typedef struct {
        int                len;
        logic [0:7][15:0]  s;
        int                t0;
        int                n_rec;
        int                vcyc;
        int                peak;
        int                pt;
        int                w;
        int                pile;
    } vec_t;

    vec_t tbl[5];

    initial begin
        reset = 1'b1;
        input_data = '0;
        result_ready = 1'b0;

        tbl[0] = '{7, {16'd0, 16'd50, 16'd150, 16'd300, 16'd250, 16'd120,
                       16'd60, 16'd0}, 10, 1, 18, 300, 13, 4, 0};
        tbl[1] = '{5, {16'd150, 16'd300, 16'd300, 16'd90, 16'd70, 16'd0,
                       16'd0, 16'd0}, 5, 1, 11, 300, 6, 4, 0};
        tbl[2] = '{6, {16'd200, 16'd400, 16'd250, 16'd220, 16'd300, 16'd50,
                       16'd0, 16'd0}, 0, 1, 7, 400, 1, 5, 1};
        tbl[3] = '{6, {16'd200, 16'd400, 16'd250, 16'd220, 16'd235, 16'd50,
                       16'd0, 16'd0}, 0, 1, 7, 400, 1, 5, 0};
        tbl[4] = '{8, {-16'sd50, -16'sd50, -16'sd50, -16'sd50, -16'sd50,
                       -16'sd50, -16'sd50, -16'sd50}, 3, 0, -1, 0, 0, 0, 0};

        foreach (tbl[k]) begin
            do_reset();
            for (int i = 0; i < tbl[k].t0; i++) step(0, 1);
            for (int i = 0; i < tbl[k].len; i++)
                step(int'($signed(tbl[k].s[i])), 1);
            for (int i = 0; i < 6; i++) step(k == 4 ? -50 : 0, 1);
            check($sformatf("t%0d_nrec", k), valid_cnt, tbl[k].n_rec);
            check($sformatf("t%0d_vcyc", k), first_valid, tbl[k].vcyc);
            if (tbl[k].n_rec > 0) begin
                check($sformatf("t%0d_peak", k), cap_peak, tbl[k].peak);
                check($sformatf("t%0d_ptime", k), cap_pt, tbl[k].pt);
                check($sformatf("t%0d_width", k), cap_w, tbl[k].w);
                check($sformatf("t%0d_pile", k), cap_pile, tbl[k].pile);
            end
        end

        // Backpressure: second record dropped, held record intact.
        do_reset();
        step(150, 0); step(300, 0); step(50, 0); step(0, 0); step(0, 0);
        step(150, 0); step(500, 0); step(50, 0); step(0, 0); step(0, 0);
        check("bp_valid", result_valid, 1);
        check("bp_peak", peak_amplitude, 300);
        check("bp_lost", lost_count, 1);
        step(0, 1);
        check("bp_drop", result_valid, 0);

        // Accept and emit on the same edge.
        do_reset();
        step(150, 0); step(300, 0); step(50, 0); step(0, 0); step(0, 0);
        step(150, 0); step(500, 0); step(50, 0);
        step(0, 1); step(0, 0);
        check("sim_valid", result_valid, 1);
        check("sim_peak", peak_amplitude, 500);
        check("sim_lost", lost_count, 0);

        // Width saturation.
        do_reset();
        for (int i = 0; i < 5000; i++) step(150, 1);
        step(0, 1); step(0, 1); step(0, 1);
        check("ovf_width", cap_w, 4095);
        check("ovf_flag", cap_ovf, 1);

        // Reset in the middle of a pulse.
        do_reset();
        step(150, 1); step(300, 1); step(350, 1);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1);
        check("rstmid_nrec", valid_cnt, 0);

        // Random streams with random backpressure.
        do_reset();
        begin
            bit hi = 0;
            for (int i = 0; i < 4000; i++) begin
                int v;
                if ($urandom_range(0, 7) == 0) hi = !hi;
                v = hi ? int'($urandom_range(60, 600))
                       : int'($urandom_range(0, 290)) - 200;
                step(v, $urandom_range(0, 9) < 7);
            end
        end
        for (int i = 0; i < 4; i++) step(0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
